// File: rtl/stack_pop_reader_pkg.sv
// Shared definitions for the stack drain controller: FSM encodings and skid buffer depth.
package stack_pop_reader_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int BUF_DEPTH = 3;
endpackage

// File: rtl/stack_pop_reader_skid_buf.sv
// pop_skid_buf: 3-entry register FIFO absorbing in-flight pop results; head visible same cycle.
// Enqueue and dequeue may coincide; enqueue into a full buffer without dequeue is dropped.
module pop_skid_buf
   import stack_pop_reader_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_enq,
   input  logic [N-1:0] i_enq_data,
   input  logic         i_deq,
   output logic [1:0]   o_occ,
   output logic [N-1:0] o_head
);
   localparam logic [1:0] LAST_IDX = 2'(BUF_DEPTH - 1);
   localparam logic [1:0] FULL_OCC = 2'(BUF_DEPTH);

   logic [N-1:0] r_mem [BUF_DEPTH];
   logic [1:0]   r_head_ptr;
   logic [1:0]   r_tail_ptr;
   logic [1:0]   r_occ;
   logic         w_do_deq;
   logic         w_do_enq;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
   endfunction

   assign w_do_deq = i_deq && (r_occ != 2'd0);
   assign w_do_enq = i_enq && ((r_occ != FULL_OCC) || w_do_deq);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
         r_head_ptr <= 2'd0;
         r_tail_ptr <= 2'd0;
         r_occ      <= 2'd0;
      end else begin
         if (w_do_enq) begin
            r_mem[r_tail_ptr] <= i_enq_data;
            r_tail_ptr        <= ptr_inc(r_tail_ptr);
         end
         if (w_do_deq) r_head_ptr <= ptr_inc(r_head_ptr);
         case ({w_do_enq, w_do_deq})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_mem[r_head_ptr];
endmodule

// File: rtl/stack_pop_reader.sv
// Drains a LIFO stack by issuing pops and streaming results out on valid/ready.
// Pop issue is throttled by buffer room plus the in-flight pop, so out_ready never reaches stk_pop.
module stack_pop_reader
   import stack_pop_reader_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_burst_len,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_short,
   output logic [CNT_W-1:0] o_popped_cnt,
   output logic             o_stk_pop,
   input  logic [N-1:0]     i_stk_pop_data,
   input  logic             i_stk_valid,
   input  logic             i_stk_empty,
   output logic             o_out_valid,
   output logic [N-1:0]     o_out_data,
   input  logic             i_out_ready
);
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_burst_len;
   logic [CNT_W-1:0] r_popped_cnt;
   logic             r_short;
   logic             r_inflight;

   logic [CNT_W-1:0] w_target;
   logic [CNT_W:0]   w_pending;
   logic             w_room;
   logic             w_reached;
   logic             w_stk_pop;
   logic             w_accept;
   logic             w_deq;
   logic [1:0]       w_occ;
   logic [N-1:0]     w_head;
   logic             w_launch;
   logic             w_finish;
   logic             w_finish_short;

   // A zero burst length means "drain until empty", capped at the counter maximum.
   assign w_target  = (r_burst_len == '0) ? '1 : r_burst_len;
   assign w_pending = {1'b0, r_popped_cnt} + {{CNT_W{1'b0}}, r_inflight};
   assign w_room    = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(BUF_DEPTH);
   assign w_reached = (r_popped_cnt >= w_target);
   assign w_stk_pop = (r_state == ST_RUN) && !i_stk_empty && w_room &&
                      (w_pending < {1'b0, w_target});
   assign w_accept  = r_inflight && i_stk_valid;
   assign w_deq     = (w_occ != 2'd0) && i_out_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_launch       = 1'b0;
      w_finish       = 1'b0;
      w_finish_short = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_RUN;
               w_launch    = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_reached) begin
               w_state_nxt = ST_FLUSH;
               w_finish    = 1'b1;
            end else if (i_stk_empty && !r_inflight) begin
               w_state_nxt    = ST_FLUSH;
               w_finish       = 1'b1;
               w_finish_short = (r_burst_len != '0);
            end
         end
         ST_FLUSH: begin
            if (w_occ == 2'd0) w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_burst_len  <= '0;
         r_popped_cnt <= '0;
         r_short      <= 1'b0;
         r_inflight   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_stk_pop;
         if (w_launch) begin
            r_burst_len  <= i_burst_len;
            r_popped_cnt <= '0;
            r_short      <= 1'b0;
         end else begin
            if (w_accept && !w_reached) r_popped_cnt <= r_popped_cnt + 1'b1;
            if (w_finish) r_short <= w_finish_short;
         end
      end
   end

   pop_skid_buf #(
      .N (N)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .i_enq      (w_accept),
      .i_enq_data (i_stk_pop_data),
      .i_deq      (w_deq),
      .o_occ      (w_occ),
      .o_head     (w_head)
   );

   assign o_busy       = (r_state != ST_IDLE);
   assign o_done       = (r_state == ST_DONE);
   assign o_short      = r_short;
   assign o_popped_cnt = r_popped_cnt;
   assign o_stk_pop    = w_stk_pop;
   assign o_out_valid  = (w_occ != 2'd0);
   assign o_out_data   = w_head;
endmodule

// File: tb/tb_stack_pop_reader.sv
// Directed bench for stack_pop_reader with a behavioural stack (push wins over a colliding pop).
module tb_stack_pop_reader;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] burst_len;
   logic       busy, done, short_f;
   logic [7:0] popped_cnt;
   logic       stk_pop;
   logic [7:0] stk_pop_data = 8'h00;
   logic       stk_valid = 1'b0;
   logic       stk_empty;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   logic       tb_push, tb_clear;
   logic [7:0] push_data;
   logic [7:0] stk_mem [0:15];
   int         stk_cnt = 0;

   int total = 0, bad = 0;
   int cyc = 0, start_cyc = 0;
   logic [7:0] exp_q [$];
   int deq_rel [$];
   int done_rel, first_pop_rel, first_vld_rel, n_pops, pops_by8;
   int err_empty_pop, err_occ, occ_m;
   logic infl_m;

   always #5 clk = ~clk;

   stack_pop_reader #(.N(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .i_start(start), .i_burst_len(burst_len),
      .o_busy(busy), .o_done(done), .o_short(short_f), .o_popped_cnt(popped_cnt),
      .o_stk_pop(stk_pop), .i_stk_pop_data(stk_pop_data), .i_stk_valid(stk_valid),
      .i_stk_empty(stk_empty), .o_out_valid(out_valid), .o_out_data(out_data),
      .i_out_ready(out_ready)
   );

   assign stk_empty = (stk_cnt == 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      stk_valid <= 1'b0;
      if (tb_clear) stk_cnt <= 0;
      else if (tb_push) begin
         stk_mem[stk_cnt] <= push_data;
         stk_cnt <= stk_cnt + 1;
      end else if (stk_pop && stk_cnt > 0) begin
         stk_pop_data <= stk_mem[stk_cnt-1];
         stk_valid <= 1'b1;
         stk_cnt <= stk_cnt - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      int rel;
      rel = cyc - start_cyc + 1;
      if (reset) begin
         occ_m = 0;
         infl_m = 1'b0;
      end else begin
         if (stk_pop && stk_empty) err_empty_pop++;
         if ((occ_m + int'(infl_m) > 3) || (out_valid !== (occ_m != 0))) err_occ++;
         if (stk_pop) begin
            n_pops++;
            if (rel <= 8) pops_by8++;
            if (first_pop_rel < 0) first_pop_rel = rel;
         end
         if (out_valid && first_vld_rel < 0) first_vld_rel = rel;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL out_unexpected observed=%0h expected=none", out_data);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
            end
            deq_rel.push_back(rel);
         end
         if (done) done_rel = rel;
         occ_m = occ_m + int'(infl_m && stk_valid) - int'(out_valid && out_ready);
         infl_m = stk_pop;
      end
   end

   task automatic load_stack(input logic [7:0] base, input int n);
      @(posedge clk); #1 tb_clear = 1'b1;
      @(posedge clk); #1 tb_clear = 1'b0;
      for (int i = 0; i < n; i++) begin
         push_data = base + 8'(i);
         tb_push = 1'b1;
         @(posedge clk); #1 tb_push = 1'b0;
      end
   endtask

   task automatic expect_top(input logic [7:0] base, input int n, input int cnt);
      for (int i = 0; i < cnt; i++) exp_q.push_back(base + 8'(n - 1 - i));
   endtask

   task automatic do_start(input logic [7:0] len);
      @(posedge clk); #1;
      start = 1'b1;
      burst_len = len;
      deq_rel.delete();
      done_rel = -1; first_pop_rel = -1; first_vld_rel = -1;
      n_pops = 0; pops_by8 = 0; err_empty_pop = 0; err_occ = 0;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      #1;
      if (!done) begin
         total++;
         bad++;
         $error("FAIL %s_timeout observed=no_done expected=done", tag);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; burst_len = 8'd0; out_ready = 1'b1;
      tb_push = 1'b0; tb_clear = 1'b0; push_data = 8'd0;
      #12;
      check("rst_stk_pop", stk_pop, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_short", short_f, 0);
      check("rst_popped", popped_cnt, 0);
      @(posedge clk); #1 reset = 1'b0;

      // burst of 3 from 5 entries, timing checked
      load_stack(8'hA0, 5);
      expect_top(8'hA0, 5, 3);
      do_start(8'd3);
      wait_done("t1");
      check("t1_first_pop", first_pop_rel, 1);
      check("t1_first_vld", first_vld_rel, 3);
      check("t1_ndeq", deq_rel.size(), 3);
      if (deq_rel.size() == 3) begin
         check("t1_deq0", deq_rel[0], 3);
         check("t1_deq1", deq_rel[1], 4);
         check("t1_deq2", deq_rel[2], 5);
      end
      check("t1_done_cyc", done_rel, 7);
      check("t1_popped", popped_cnt, 3);
      check("t1_short", short_f, 0);
      check("t1_stk_left", stk_cnt, 2);
      check("t1_busy_done", busy, 1);
      @(negedge clk);
      check("t1_busy_after", busy, 0);
      check("t1_done_after", done, 0);

      // drain-until-empty
      load_stack(8'hB0, 4);
      expect_top(8'hB0, 4, 4);
      do_start(8'd0);
      wait_done("t2");
      check("t2_popped", popped_cnt, 4);
      check("t2_short", short_f, 0);
      check("t2_left", exp_q.size(), 0);

      // stack runs dry before burst_len
      load_stack(8'hC0, 2);
      expect_top(8'hC0, 2, 2);
      do_start(8'd6);
      wait_done("t3");
      check("t3_popped", popped_cnt, 2);
      check("t3_short", short_f, 1);
      check("t3_empty_pop", err_empty_pop, 0);
      check("t3_left", exp_q.size(), 0);

      // consumer stalls cycles 2..8
      load_stack(8'hD0, 5);
      expect_top(8'hD0, 5, 5);
      do_start(8'd5);
      @(posedge clk); #1 out_ready = 1'b0;
      repeat (7) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done("t4");
      check("t4_occ", err_occ, 0);
      check("t4_pops_stall", pops_by8, 3);
      check("t4_popped", popped_cnt, 5);
      check("t4_left", exp_q.size(), 0);

      // push collides with a pop in cycle 2: pop lost, reissued, pushed value comes next
      load_stack(8'hE0, 5);
      exp_q.push_back(8'hE4);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hE3);
      do_start(8'd3);
      @(posedge clk); #1;
      check("t5_pop_c2", stk_pop, 1);
      push_data = 8'h5A;
      tb_push = 1'b1;
      @(posedge clk); #1 tb_push = 1'b0;
      wait_done("t5");
      check("t5_popped", popped_cnt, 3);
      check("t5_npops", n_pops, 4);
      check("t5_stk_left", stk_cnt, 3);
      check("t5_left", exp_q.size(), 0);

      // reset in cycle 4 aborts, stack keeps what is left
      load_stack(8'hF0, 5);
      expect_top(8'hF0, 5, 5);
      do_start(8'd5);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("t6_stk_pop", stk_pop, 0);
      check("t6_out_valid", out_valid, 0);
      check("t6_out_data", out_data, 0);
      check("t6_busy", busy, 0);
      check("t6_popped", popped_cnt, 0);
      check("t6_short", short_f, 0);
      @(posedge clk); #1 reset = 1'b0;
      exp_q.delete();
      check("t6_stk_left", stk_cnt, 2);
      expect_top(8'hF0, 2, 2);
      do_start(8'd0);
      wait_done("t6b");
      check("t6b_popped", popped_cnt, 2);
      check("t6b_short", short_f, 0);
      check("t6b_left", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
